bp_io_cmd_wormhole_arbiter: RTL and testbench



---
 rtl/bp_me_pkg.sv | 20 ++
 rtl/bp_io_rr_picker.sv | 39 +++
 rtl/bp_io_cmd_wormhole_arbiter.sv | 139 +++++++++++++
 tb/tb_bp_io_cmd_wormhole_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared I/O NoC widths, wormhole header and arbiter state types
package bp_me_pkg;

    localparam int io_noc_flit_width_p = 16;
    localparam int io_noc_cord_width_p = 4;
    localparam int io_noc_len_width_p  = 3;

    // Header occupies the low bits of the first flit: len above cord.
    typedef struct packed {
        logic [io_noc_len_width_p-1:0]  len;
        logic [io_noc_cord_width_p-1:0] cord;
    } bp_io_wh_hdr_s;

    typedef enum logic [1:0] {
        e_idle,
        e_hdr,
        e_body
    } bp_io_wh_arb_state_e;

endpackage

// File: rtl/bp_io_rr_picker.sv
// rtl/bp_io_rr_picker.sv - combinational round-robin picker starting after last
//
// Ports:
//   req       - request vector
//   last      - index of the previous winner; search starts at last+1
//   grant     - one-hot winner, all zero when no request
//   grant_idx - index of the winner, zero when no request
module bp_io_rr_picker #(
    parameter int num_req_p    = 4,
    parameter int lg_num_req_p = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]    req,
    input  logic [lg_num_req_p-1:0] last,
    output logic [num_req_p-1:0]    grant,
    output logic [lg_num_req_p-1:0] grant_idx
);

    int                      idx;
    logic [lg_num_req_p-1:0] idx_c;

    // Walk from the lowest priority (offset num_req_p, i.e. last itself)
    // to the highest (offset 1); later hits overwrite earlier ones.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        idx_c     = '0;
        for (int off = num_req_p; off >= 1; off--) begin
            idx   = (int'(last) + off) % num_req_p;
            idx_c = lg_num_req_p'(idx);
            if (req[idx_c]) begin
                grant        = '0;
                grant[idx_c] = 1'b1;
                grant_idx    = idx_c;
            end
        end
    end

endmodule

// File: rtl/bp_io_cmd_wormhole_arbiter.sv
// rtl/bp_io_cmd_wormhole_arbiter.sv - packet-atomic round-robin merge of io_cmd wormhole streams
//
// Ports:
//   io_clk_i, io_reset_n_i  - clock, synchronous active-low reset
//   data_i, v_i, ready_and_o - per-requester flit streams (ready-and handshake)
//   data_o, v_o, ready_and_i - merged link stream
//   grant_o                  - one-hot current owner, zero when none
//   busy_o                   - a packet is locked (HDR or BODY)
module bp_io_cmd_wormhole_arbiter
    import bp_me_pkg::*;
#(
    parameter int num_req_p    = 4,
    parameter int flit_width_p = io_noc_flit_width_p,
    parameter int cord_width_p = io_noc_cord_width_p,
    parameter int len_width_p  = io_noc_len_width_p
) (
    input  logic                              io_clk_i,
    input  logic                              io_reset_n_i,
    input  logic [num_req_p*flit_width_p-1:0] data_i,
    input  logic [num_req_p-1:0]              v_i,
    output logic [num_req_p-1:0]              ready_and_o,
    output logic [flit_width_p-1:0]           data_o,
    output logic                              v_o,
    input  logic                              ready_and_i,
    output logic [num_req_p-1:0]              grant_o,
    output logic                              busy_o
);

    localparam int lg_w = $clog2(num_req_p);

    bp_io_wh_arb_state_e state_r, state_n;
    logic [len_width_p-1:0] cnt_r, cnt_n;
    logic [lg_w-1:0]        owner_r, owner_n;
    logic [lg_w-1:0]        last_r, last_n;

    logic [num_req_p-1:0]    pick_grant;
    logic [lg_w-1:0]         pick_idx;
    logic [num_req_p-1:0]    locked_oh;
    logic [num_req_p-1:0]    owner_oh;
    logic [lg_w-1:0]         owner_idx;
    logic                    idle;
    logic                    hs;
    logic [len_width_p-1:0]  hdr_len;
    logic [flit_width_p-1:0] req_flit [num_req_p];

    bp_io_rr_picker #(
        .num_req_p    (num_req_p),
        .lg_num_req_p (lg_w)
    ) picker (
        .req       (v_i),
        .last      (last_r),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    for (genvar k = 0; k < num_req_p; k++) begin : g_unpack
        assign req_flit[k] = data_i[k*flit_width_p +: flit_width_p];
    end

    always_comb begin
        locked_oh          = '0;
        locked_oh[owner_r] = 1'b1;
    end

    // Only IDLE consults the picker; once locked, v_i changes cannot move the grant.
    assign idle      = (state_r == e_idle);
    assign owner_oh  = idle ? pick_grant : locked_oh;
    assign owner_idx = idle ? pick_idx : owner_r;

    assign data_o      = req_flit[owner_idx];
    assign grant_o     = io_reset_n_i ? owner_oh : '0;
    assign v_o         = io_reset_n_i & (|(v_i & owner_oh));
    assign ready_and_o = grant_o & {num_req_p{ready_and_i}};
    assign busy_o      = io_reset_n_i & ~idle;

    assign hs      = v_o & ready_and_i;
    assign hdr_len = data_o[cord_width_p +: len_width_p];

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        owner_n = owner_r;
        last_n  = last_r;
        case (state_r)
            e_idle: begin
                if (hs) begin
                    if (hdr_len == '0) begin
                        last_n = pick_idx;
                    end else begin
                        state_n = e_body;
                        cnt_n   = hdr_len;
                        owner_n = pick_idx;
                    end
                end else if (|v_i) begin
                    state_n = e_hdr;
                    owner_n = pick_idx;
                end
            end
            e_hdr: begin
                if (hs) begin
                    if (hdr_len == '0) begin
                        state_n = e_idle;
                        last_n  = owner_r;
                    end else begin
                        state_n = e_body;
                        cnt_n   = hdr_len;
                    end
                end
            end
            e_body: begin
                if (hs) begin
                    cnt_n = cnt_r - len_width_p'(1);
                    if (cnt_r == len_width_p'(1)) begin
                        state_n = e_idle;
                        last_n  = owner_r;
                    end
                end
            end
            default: begin
                state_n = e_idle;
            end
        endcase
    end

    always_ff @(posedge io_clk_i) begin
        if (!io_reset_n_i) begin
            state_r <= e_idle;
            cnt_r   <= '0;
            owner_r <= '0;
            last_r  <= lg_w'(num_req_p - 1);
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            owner_r <= owner_n;
            last_r  <= last_n;
        end
    end

endmodule

// File: tb/tb_bp_io_cmd_wormhole_arbiter.sv
// tb/tb_bp_io_cmd_wormhole_arbiter.sv - self-checking bench for bp_io_cmd_wormhole_arbiter
module tb_bp_io_cmd_wormhole_arbiter;
    import bp_me_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] data_i;
    logic [3:0]  v_i;
    logic [3:0]  ready_and_o;
    logic [15:0] data_o;
    logic        v_o;
    logic        ready_and_i;
    logic [3:0]  grant_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bp_io_cmd_wormhole_arbiter dut (
        .io_clk_i     (clk),
        .io_reset_n_i (rstn),
        .data_i       (data_i),
        .v_i          (v_i),
        .ready_and_o  (ready_and_o),
        .data_o       (data_o),
        .v_o          (v_o),
        .ready_and_i  (ready_and_i),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic        rstn;
        logic        rdy;
        logic [3:0]  v;
        logic [63:0] d;
        logic        vo;
        logic [15:0] dout;
        logic        chkd;
        logic [3:0]  gnt;
        logic        busy;
        logic        chkl;
        logic [1:0]  last;
    } vec_t;

    vec_t tbl[$];

    logic [15:0] sbuf [4][64];
    int          shead [4];
    int          stail [4];
    int          log_src[$];
    logic [15:0] log_flit[$];
    int          exp_src[$];
    logic [15:0] exp_flit[$];

    function automatic logic [15:0] hdr(input int src, input int len, input int cord);
        bp_io_wh_hdr_s h;
        h.len  = io_noc_len_width_p'(len);
        h.cord = io_noc_cord_width_p'(cord);
        return {4'hA, 4'(src), 1'b0, h};
    endfunction

    function automatic logic [15:0] bod(input int src, input int seq);
        return {4'hB, 4'(src), 8'(seq)};
    endfunction

    function automatic logic [63:0] slot(input int src, input logic [15:0] f);
        logic [63:0] r;
        r = 64'(f) << (16 * src);
        return r;
    endfunction

    function automatic vec_t mk(input logic r, input logic rdy, input logic [3:0] v,
                                input logic [63:0] d, input logic vo, input logic [15:0] dout,
                                input logic chkd, input logic [3:0] gnt, input logic busy,
                                input logic chkl, input logic [1:0] last);
        vec_t x;
        x.rstn = r; x.rdy = rdy; x.v = v; x.d = d; x.vo = vo; x.dout = dout;
        x.chkd = chkd; x.gnt = gnt; x.busy = busy; x.chkl = chkl; x.last = last;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int src, input logic [15:0] f);
        sbuf[src][stail[src]] = f;
        stail[src]++;
    endtask

    // One clock of source-model traffic: drive at negedge, sample 1 time unit later.
    task automatic cycle(input logic rdy, input logic r);
        @(negedge clk);
        rstn        = r;
        ready_and_i = rdy;
        for (int k = 0; k < 4; k++) begin
            if (shead[k] != stail[k]) begin
                v_i[k]            = 1'b1;
                data_i[k*16 +: 16] = sbuf[k][shead[k]];
            end else begin
                v_i[k]            = 1'b0;
                data_i[k*16 +: 16] = 16'h0;
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            if (ready_and_o[k] && v_i[k]) begin
                chk("hs_data", 64'(data_o), 64'(sbuf[k][shead[k]]));
                log_src.push_back(k);
                log_flit.push_back(sbuf[k][shead[k]]);
                shead[k]++;
            end
        end
    endtask

    task automatic expect_pkt(input int src, input int len, input int cord);
        exp_src.push_back(src);
        exp_flit.push_back(hdr(src, len, cord));
        for (int b = 1; b <= len; b++) begin
            exp_src.push_back(src);
            exp_flit.push_back(bod(src, b));
        end
    endtask

    task automatic send_pkt(input int src, input int len, input int cord);
        push(src, hdr(src, len, cord));
        for (int b = 1; b <= len; b++) push(src, bod(src, b));
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_count"}, 64'(log_src.size()), 64'(exp_src.size()));
        for (int i = 0; i < exp_src.size() && i < log_src.size(); i++) begin
            chk({nm, "_src"}, 64'(log_src[i]), 64'(exp_src[i]));
            chk({nm, "_flit"}, 64'(log_flit[i]), 64'(exp_flit[i]));
        end
        log_src.delete(); log_flit.delete(); exp_src.delete(); exp_flit.delete();
    endtask

    initial begin
        rstn        = 1'b0;
        data_i      = '0;
        v_i         = '0;
        ready_and_i = 1'b0;
        for (int k = 0; k < 4; k++) begin shead[k] = 0; stail[k] = 0; end

        // Reset state
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk("rst_v_o", 64'(v_o), 64'h0);
        chk("rst_grant", 64'(grant_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_ready", 64'(ready_and_o), 64'h0);

        // Single packet from req 1 (len 3), then zero-length headers from req 3 under back-pressure
        tbl.push_back(mk(0, 1, 4'b0010, slot(1, hdr(1,3,5)), 0, 16'h0, 0, 4'b0000, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 4'b0010, slot(1, hdr(1,3,5)), 1, hdr(1,3,5), 1, 4'b0010, 0, 1, 2'd3));
        tbl.push_back(mk(1, 1, 4'b0010, slot(1, bod(1,1)), 1, bod(1,1), 1, 4'b0010, 1, 0, 2'd0));
        tbl.push_back(mk(1, 1, 4'b0010, slot(1, bod(1,2)), 1, bod(1,2), 1, 4'b0010, 1, 0, 2'd0));
        tbl.push_back(mk(1, 1, 4'b0010, slot(1, bod(1,3)), 1, bod(1,3), 1, 4'b0010, 1, 0, 2'd0));
        tbl.push_back(mk(1, 1, 4'b0000, 64'h0, 0, 16'h0, 1, 4'b0000, 0, 1, 2'd1));
        tbl.push_back(mk(1, 1, 4'b1000, slot(3, hdr(3,0,2)), 1, hdr(3,0,2), 1, 4'b1000, 0, 1, 2'd1));
        tbl.push_back(mk(1, 0, 4'b1000, slot(3, hdr(3,0,6)), 1, hdr(3,0,6), 1, 4'b1000, 0, 1, 2'd3));
        tbl.push_back(mk(1, 1, 4'b1000, slot(3, hdr(3,0,6)), 1, hdr(3,0,6), 1, 4'b1000, 1, 1, 2'd3));
        tbl.push_back(mk(1, 1, 4'b0000, 64'h0, 0, 16'h0, 0, 4'b0000, 0, 1, 2'd3));

        foreach (tbl[i]) begin
            @(negedge clk);
            rstn        = tbl[i].rstn;
            ready_and_i = tbl[i].rdy;
            v_i         = tbl[i].v;
            data_i      = tbl[i].d;
            #1;
            chk($sformatf("vec%0d_v_o", i), 64'(v_o), 64'(tbl[i].vo));
            chk($sformatf("vec%0d_grant", i), 64'(grant_o), 64'(tbl[i].gnt));
            chk($sformatf("vec%0d_ready", i), 64'(ready_and_o), 64'(tbl[i].gnt & {4{tbl[i].rdy}}));
            chk($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(tbl[i].busy));
            if (tbl[i].chkd) chk($sformatf("vec%0d_data", i), 64'(data_o), 64'(tbl[i].dout));
            if (tbl[i].chkl) chk($sformatf("vec%0d_last", i), 64'(dut.last_r), 64'(tbl[i].last));
        end

        // Contention: reqs 0, 2, 3 each offer two len=1 packets
        for (int p = 0; p < 2; p++) begin
            send_pkt(0, 1, p); send_pkt(2, 1, p); send_pkt(3, 1, p);
        end
        for (int p = 0; p < 2; p++) begin
            expect_pkt(0, 1, p); expect_pkt(2, 1, p); expect_pkt(3, 1, p);
        end
        for (int c = 0; c < 12; c++) cycle(1'b1, 1'b1);
        check_log("rr");

        // Header stall lock: req 2 holds grant while req 0 appears
        send_pkt(2, 1, 3);
        cycle(1'b0, 1'b1);
        chk("stall0_grant", 64'(grant_o), 64'h4);
        send_pkt(0, 1, 4);
        for (int c = 1; c < 3; c++) begin
            cycle(1'b0, 1'b1);
            chk("stall_grant", 64'(grant_o), 64'h4);
            chk("stall_data", 64'(data_o), 64'(hdr(2, 1, 3)));
            chk("stall_ready", 64'(ready_and_o), 64'h0);
        end
        for (int c = 0; c < 4; c++) cycle(1'b1, 1'b1);
        expect_pkt(2, 1, 3); expect_pkt(0, 1, 4);
        check_log("stall");

        // Max length: req 0 len=7 must hold the link for 8 handshakes; req 1 waits
        send_pkt(0, 7, 1);
        cycle(1'b1, 1'b1);
        chk("max_grant0", 64'(grant_o), 64'h1);
        push(1, hdr(1, 0, 2));
        for (int c = 1; c < 8; c++) begin
            cycle(1'b1, 1'b1);
            chk($sformatf("max_grant%0d", c), 64'(grant_o), 64'h1);
        end
        cycle(1'b1, 1'b1);
        chk("max_release", 64'(grant_o), 64'h2);
        expect_pkt(0, 7, 1); expect_pkt(1, 0, 2);
        check_log("max");

        // Mid-packet reset during BODY with cnt_r==2
        send_pkt(2, 3, 7);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        chk("mrst_cnt", 64'(dut.cnt_r), 64'h2);
        chk("mrst_v_o", 64'(v_o), 64'h0);
        chk("mrst_grant", 64'(grant_o), 64'h0);
        chk("mrst_ready", 64'(ready_and_o), 64'h0);
        chk("mrst_busy", 64'(busy_o), 64'h0);
        shead[2] = stail[2];
        log_src.delete(); log_flit.delete();
        cycle(1'b1, 1'b1);
        chk("post_rst_v_o", 64'(v_o), 64'h0);
        chk("post_rst_grant", 64'(grant_o), 64'h0);
        chk("post_rst_busy", 64'(busy_o), 64'h0);
        chk("post_rst_last", 64'(dut.last_r), 64'h3);
        push(0, hdr(0, 0, 1));
        push(3, hdr(3, 0, 2));
        cycle(1'b1, 1'b1);
        chk("post_rst_first", 64'(grant_o), 64'h1);
        cycle(1'b1, 1'b1);
        chk("post_rst_second", 64'(grant_o), 64'h8);
        expect_pkt(0, 0, 1); expect_pkt(3, 0, 2);
        check_log("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
